// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter slice.
// Default widths match the APB master's system-task interface.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_WD_LIMIT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Reusable for any shared resource.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  localparam int PW = IDX_W + 1;

  logic [IDX_W:0] pos;
  logic           found;

  // Walk the requesters starting at ptr; the extra pos bit absorbs the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        grant[pos[IDX_W-1:0]] = 1'b1;
        grant_idx             = pos[IDX_W-1:0];
        found                 = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester front end for the APB master: round-robin grant, one
// transaction in flight, response routing and a backstop watchdog.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WD_LIMIT = DEF_WD_LIMIT
) (
  input  logic                      apb_clk,
  input  logic                      apb_reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0]          req_dir,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_data_valid,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_data_dir,
  input  logic [DATA_W-1:0]         m_read_out_data,
  input  logic                      m_transaction_done,
  input  logic                      m_tranerr,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(WD_LIMIT + 1);

  arb_state_e        state, next_state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              req_any;

  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_dir;
  logic [IDX_W-1:0]  owner;
  logic [WD_W-1:0]   wd_cnt;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              wd_hit;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (req_any)
  );

  assign wd_hit = (wd_cnt == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    m_data_valid = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req_ready = grant;
        if (req_any) begin
          next_state = S_ISSUE;
        end
      end
      // Single-cycle launch so the master does not restart after completing.
      S_ISSUE: begin
        m_data_valid = 1'b1;
        next_state   = S_WAIT;
      end
      S_WAIT: begin
        if (m_transaction_done || m_tranerr || wd_hit) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner] = 1'b1;
        rsp_rdata        = rsp_data_q;
        rsp_err          = rsp_err_q;
        next_state       = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Command capture, pointer advance, watchdog and completion latch.
  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      rr_ptr     <= '0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      cmd_dir    <= 1'b0;
      owner      <= '0;
      wd_cnt     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            cmd_addr <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            cmd_dir  <= req_dir[grant_idx];
            cmd_data <= (req_dir[grant_idx] == DIR_READ) ? '0
                        : req_wdata[grant_idx*DATA_W +: DATA_W];
            owner    <= grant_idx;
            if (grant_idx == IDX_W'(N_REQ - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= grant_idx + IDX_W'(1);
            end
          end
        end
        // Done outranks a simultaneous tranerr; the watchdog is the last resort.
        S_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (m_transaction_done) begin
            rsp_data_q <= (cmd_dir == DIR_READ) ? m_read_out_data : '0;
            rsp_err_q  <= 1'b0;
          end else if (m_tranerr || wd_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        S_RESP: begin
          wd_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign m_addr     = cmd_addr;
  assign m_data     = cmd_data;
  assign m_data_dir = cmd_dir;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized scoreboard bench for apb_req_arbiter with a behavioural
// master/slave stand-in and a directed mid-transaction reset at the end.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WD = 64;

  localparam int K_OK      = 0;
  localparam int K_SLVERR  = 1;
  localparam int K_TIMEOUT = 2;
  localparam int K_BOTH    = 3;
  localparam int K_SILENT  = 4;

  logic              apb_clk;
  logic              apb_reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_dir;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     m_addr;
  logic              m_data_valid;
  logic [DW-1:0]     m_data;
  logic              m_data_dir;
  logic [DW-1:0]     m_read_out_data;
  logic              m_transaction_done;
  logic              m_tranerr;
  logic              busy;

  apb_req_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WD_LIMIT(WD)
  ) dut (
    .apb_clk            (apb_clk),
    .apb_reset_n        (apb_reset_n),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_dir            (req_dir),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .m_addr             (m_addr),
    .m_data_valid       (m_data_valid),
    .m_data             (m_data),
    .m_data_dir         (m_data_dir),
    .m_read_out_data    (m_read_out_data),
    .m_transaction_done (m_transaction_done),
    .m_tranerr          (m_tranerr),
    .busy               (busy)
  );

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  int cyc = 0;
  always @(posedge apb_clk) cyc <= cyc + 1;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } rsp_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          dir;
    int            kind;
    int            d;
  } iss_t;

  rsp_t rsp_q[$];
  iss_t iss_q[$];

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_wdata [N];
  logic          p_dir   [N];
  int            p_kind  [N];
  int            p_d     [N];
  logic          accepted[N];

  logic [DW-1:0] ref_mem   [256];
  logic [DW-1:0] slave_mem [256];

  logic mon_en = 1'b0;
  logic gen_en = 1'b0;
  int   ref_ptr = 0;
  int   free_cyc = 0;
  logic m_active = 1'b0;
  int   m_fire_cyc = 0;
  int   m_kind = 0;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_dir   = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
      req_dir[i]            = p_dir[i];
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  task automatic new_fields(input int i);
    int r;
    p_addr[i]  = AW'($urandom_range(0, 7));
    p_wdata[i] = $urandom;
    p_dir[i]   = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 31);
    if (r < 22)      begin p_kind[i] = K_OK;      p_d[i] = $urandom_range(0, 3); end
    else if (r < 25) begin p_kind[i] = K_SLVERR;  p_d[i] = $urandom_range(0, 2); end
    else if (r < 27) begin p_kind[i] = K_TIMEOUT; p_d[i] = 20; end
    else if (r < 30) begin p_kind[i] = K_BOTH;    p_d[i] = $urandom_range(0, 2); end
    else             begin p_kind[i] = K_SILENT;  p_d[i] = 0; end
  endtask

  // Requesters: hold until accepted, occasionally withdraw, scramble after accept.
  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) begin
        accepted[i]  = 1'b0;
        req_valid[i] = 1'b0;
        new_fields(i);
      end else if (req_valid[i]) begin
        if ($urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
      end else if (gen_en && $urandom_range(0, 3) == 0) begin
        new_fields(i);
        req_valid[i] = 1'b1;
      end
    end
  endtask

  // Master/slave stand-in: one pulse per issued transaction, timed by scenario.
  initial begin
    m_transaction_done = 1'b0;
    m_tranerr          = 1'b0;
    m_read_out_data    = '0;
    forever begin
      @(posedge apb_clk);
      #1;
      m_transaction_done = 1'b0;
      m_tranerr          = 1'b0;
      m_read_out_data    = $urandom;
      if (m_active && cyc == m_fire_cyc) begin
        m_active = 1'b0;
        if (m_kind == K_OK || m_kind == K_BOTH) begin
          m_transaction_done = 1'b1;
          m_tranerr          = (m_kind == K_BOTH);
          if (m_data_dir == DIR_READ) m_read_out_data = slave_mem[m_addr];
          else                        slave_mem[m_addr] = m_data;
        end else begin
          m_tranerr = 1'b1;
        end
      end
    end
  end

  // Reference model and scoreboard monitor, sampled on the falling edge.
  always @(negedge apb_clk) begin
    logic [N-1:0] exp_ready;
    logic         exp_busy;
    int           g;
    rsp_t         e;
    iss_t         s;
    if (mon_en) begin
      exp_busy  = (cyc < free_cyc);
      exp_ready = '0;
      g         = -1;
      if (!exp_busy) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(ref_ptr + k) % N]) g = (ref_ptr + k) % N;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check_output("req_ready", 64'(req_ready), 64'(exp_ready));
      check_output("busy", 64'(busy), 64'(exp_busy));

      if (g >= 0) begin
        accepted[g] = 1'b1;
        ref_ptr     = (g + 1) % N;
        e.owner = g;
        e.rdata = '0;
        e.err   = 1'b0;
        if (p_kind[g] == K_OK || p_kind[g] == K_BOTH) begin
          if (p_dir[g] == DIR_READ) e.rdata = ref_mem[p_addr[g]];
          else                      ref_mem[p_addr[g]] = p_wdata[g];
        end else begin
          e.err = 1'b1;
        end
        e.cyc = (p_kind[g] == K_SILENT) ? cyc + WD + 2 : cyc + 5 + p_d[g];
        rsp_q.push_back(e);
        free_cyc = e.cyc + 1;
        s.cyc  = cyc + 1;
        s.addr = p_addr[g];
        s.data = (p_dir[g] == DIR_READ) ? '0 : p_wdata[g];
        s.dir  = p_dir[g];
        s.kind = p_kind[g];
        s.d    = p_d[g];
        iss_q.push_back(s);
      end

      if (m_data_valid) begin
        if (iss_q.size() == 0) begin
          report_fail("issue", "m_data_valid with nothing accepted");
        end else begin
          s = iss_q.pop_front();
          check_output("issue_cycle", 64'(cyc), 64'(s.cyc));
          check_output("m_addr", 64'(m_addr), 64'(s.addr));
          check_output("m_data", 64'(m_data), 64'(s.data));
          check_output("m_data_dir", 64'(m_data_dir), 64'(s.dir));
          m_kind     = s.kind;
          m_fire_cyc = cyc + 3 + s.d;
          m_active   = (s.kind != K_SILENT);
        end
      end else if (iss_q.size() > 0 && cyc > iss_q[0].cyc) begin
        report_fail("issue", "m_data_valid never pulsed");
        void'(iss_q.pop_front());
      end

      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          report_fail("rsp", $sformatf("rsp_valid=%0h with nothing outstanding", rsp_valid));
        end else begin
          e = rsp_q.pop_front();
          check_output("rsp_valid", 64'(rsp_valid), 64'(1) << e.owner);
          check_output("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check_output("rsp_err", 64'(rsp_err), 64'(e.err));
          check_output("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (rsp_q.size() > 0 && cyc > rsp_q[0].cyc) begin
        report_fail("rsp", $sformatf("no response for owner %0d", rsp_q[0].owner));
        void'(rsp_q.pop_front());
      end
    end
  end

  initial begin
    int guard;
    apb_reset_n = 1'b1;
    req_valid   = '0;
    for (int i = 0; i < N; i++) begin
      accepted[i] = 1'b0;
      new_fields(i);
    end
    for (int a = 0; a < 256; a++) begin
      ref_mem[a]   = '0;
      slave_mem[a] = '0;
    end
    #1 apb_reset_n = 1'b0;
    repeat (3) @(posedge apb_clk);
    #1;
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_m_data_valid", 64'(m_data_valid), 64'(0));
    check_output("reset_m_addr", 64'(m_addr), 64'(0));
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'(0));

    @(negedge apb_clk);
    apb_reset_n = 1'b1;
    #1;
    ref_ptr  = 0;
    free_cyc = 0;
    mon_en   = 1'b1;
    gen_en   = 1'b1;
    repeat (3000) begin
      @(posedge apb_clk);
      #1;
      apply_stimulus();
    end

    gen_en = 1'b0;
    guard  = 0;
    while (!(rsp_q.size() == 0 && iss_q.size() == 0 && req_valid == '0 && cyc >= free_cyc)) begin
      @(posedge apb_clk);
      #1;
      apply_stimulus();
      guard++;
      if (guard > 3000) begin
        report_fail("drain", "outstanding work did not retire");
        break;
      end
    end
    mon_en   = 1'b0;
    m_active = 1'b0;

    // Abandon a transaction in WAIT, then confirm the pointer restarts at 0.
    p_addr[2]  = 8'd55;
    p_wdata[2] = 32'hCAFE_0002;
    p_dir[2]   = DIR_WRITE;
    req_valid  = 4'b0100;
    @(negedge apb_clk);
    check_output("rst_grant", 64'(req_ready), 64'(4'b0100));
    @(posedge apb_clk);
    #1;
    req_valid = '0;
    repeat (2) @(posedge apb_clk);
    #1;
    check_output("rst_busy_before", 64'(busy), 64'(1));
    apb_reset_n = 1'b0;
    #1;
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_output("rst_m_data_valid", 64'(m_data_valid), 64'(0));
    check_output("rst_m_addr", 64'(m_addr), 64'(0));
    check_output("rst_m_data", 64'(m_data), 64'(0));
    check_output("rst_m_data_dir", 64'(m_data_dir), 64'(0));
    check_output("rst_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge apb_clk);
    @(negedge apb_clk);
    apb_reset_n = 1'b1;
    req_valid   = 4'b1111;
    #1;
    check_output("post_rst_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge apb_clk);
    #1;
    req_valid = '0;
    repeat (4) begin
      @(negedge apb_clk);
      check_output("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Multi-requester front end for the APB master's system-task interface (addr/data_valid/data/data_dir in, read_out_data/transaction_done/apb_tranerr back).
- Arbitrates N independent requesters round-robin.
- Issues one APB transaction at a time to the master and holds its command fields stable until the transaction completes.
- Routes completion, read data and error status back to the owning requester.
- Includes a backstop watchdog in case the master never reports completion.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- ADDR_W, 8: address width; matches master addr.
- DATA_W, 32: data width; matches master data.
- WD_LIMIT, 64: arbiter watchdog, in WAIT cycles, before forced error completion. Must exceed the master's timeout limit (20).

Ports:
- apb_clk  in  1  system/APB clock.
- apb_reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request pending; held until accepted.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_dir  in  N_REQ  1=write, 0=read.
- req_ready  out  N_REQ  one-hot accept pulse.
- rsp_valid  out  N_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid, 0 for writes/errors.
- rsp_err  out  1  completion was error (master tranerr or watchdog); valid with rsp_valid.
- m_addr  out  ADDR_W  to master addr.
- m_data_valid  out  1  to master data_valid.
- m_data  out  DATA_W  to master data.
- m_data_dir  out  1  to master data_dir.
- m_read_out_data  in  DATA_W  from master read_out_data.
- m_transaction_done  in  1  from master transaction_done.
- m_tranerr  in  1  from master apb_tranerr (combinational, ACCESS-state only).
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (async, apb_reset_n=0): state=IDLE, rr_ptr=0, all outputs 0, latched command 0, watchdog 0. Reset mid-transaction abandons it with no rsp_valid. The master is reset by the same event.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - If any request is valid: req_ready[g]=1 combinationally in that cycle.
  - At the edge: capture addr/wdata/dir/owner=g, set rr_ptr=(g+1)%N_REQ, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle): m_data_valid=1, then go to WAIT.
  - m_data_valid is a single-cycle pulse so the master's IDLE state does not re-launch after completion.
- WAIT: m_data_valid=0; m_addr/m_data/m_data_dir stay held from the capture.
  - Watchdog increments each WAIT cycle.
  - m_transaction_done=1: latch rdata=(dir==0 ? m_read_out_data : 0), err=0, go to RESP.
  - Else m_tranerr=1: latch rdata=0, err=1, go to RESP.
  - Else watchdog==WD_LIMIT-1: err=1, rdata=0, go to RESP.
  - Simultaneous done and tranerr: done wins.
- RESP (1 cycle): rsp_valid[owner]=1 with rsp_rdata/rsp_err, clear watchdog, go to IDLE. The next grant earliest in the following cycle.
- m_* command outputs hold their last value in IDLE; m_data is 0 for reads.
- Latency, request seen in IDLE at cycle 0 against a zero-wait slave: ISSUE c1, master SETUP c2, ACCESS c3, done seen c4, rsp_valid c5. Throughput is 1 transaction per 6 cycles.
- Fairness: a continuously requesting i waits at most N_REQ-1 transactions.
- A requester dropping req_valid before acceptance is legal. req_* changes after acceptance are ignored.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - DIR_READ/DIR_WRITE constants;
  - default widths.
- Sub-module rr_arbiter (N-bit request vector, pointer in, one-hot grant plus index out, purely combinational). It is reusable for other shared resources.

Test Plan:
- Single write then read: req0 writes 10 to addr 4, then reads addr 4 → rsp_valid[0] twice, rsp_err=0, second rsp_rdata=10; rsp_valid 5 cycles after acceptance with zero wait_cycle.
- Round-robin: req0..3 all valid, writes to addr 0..3, held continuously → grant order 0,1,2,3,0; each req_ready is one-hot; no back-to-back double grant.
- Slave error path: req1 reads addr 100 → rsp_valid[1] with rsp_rdata=0; other requesters are not acknowledged.
- Master timeout: slave wait_cycle=30 with master limit 20 → m_tranerr seen, rsp_valid[2] with rsp_err=1; arbiter returns to IDLE and the next request completes normally.
- Watchdog: m_transaction_done and m_tranerr held 0 → rsp_err=1 exactly WD_LIMIT=64 WAIT cycles after ISSUE.
- Reset mid-WAIT: assert apb_reset_n=0 during WAIT → all outputs 0 immediately with no rsp_valid; after release, rr_ptr=0 so req0 wins a contested grant.
